alu_packet_ctrl: RTL

//  Packet sequencer between the UART byte streams and the ALU datapath inside top.

---
 rtl/alu_packet_ctrl_if.sv | 29 ++
 rtl/alu_packet_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_packet_ctrl_if.sv
// RX byte stream, ALU request/result and TX byte stream seen by alu_packet_ctrl.
interface alu_packet_ctrl_if #(
  parameter int DataW = 32
);
  logic [7:0]       rx_data_i;
  logic             rx_valid_i;
  logic             rx_ready_o;
  logic [1:0]       alu_op_o;
  logic [DataW-1:0] alu_a_o;
  logic [DataW-1:0] alu_b_o;
  logic             alu_valid_o;
  logic             alu_ready_i;
  logic [DataW-1:0] alu_res_i;
  logic             alu_res_valid_i;
  logic [7:0]       tx_data_o;
  logic             tx_valid_o;
  logic             tx_ready_i;
  logic             err_o;

  modport master (
    input  rx_data_i, rx_valid_i, alu_ready_i, alu_res_i, alu_res_valid_i, tx_ready_i,
    output rx_ready_o, alu_op_o, alu_a_o, alu_b_o, alu_valid_o, tx_data_o, tx_valid_o, err_o
  );

  modport slave (
    output rx_data_i, rx_valid_i, alu_ready_i, alu_res_i, alu_res_valid_i, tx_ready_i,
    input  rx_ready_o, alu_op_o, alu_a_o, alu_b_o, alu_valid_o, tx_data_o, tx_valid_o, err_o
  );
endinterface

// File: rtl/alu_packet_ctrl.sv
// Packet sequencer: parses framed RX commands, drives one shared ALU per operand,
// and returns the accumulated result (or echoed payload) on TX.
module alu_packet_ctrl #(
  parameter int DataW         = 32,
  parameter int TimeoutCycles = 18000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  alu_packet_ctrl_if.master bus
);
  localparam int NB = DataW / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam logic [BW-1:0] LAST_B = BW'(NB - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TimeoutCycles - 1);

  typedef enum logic [2:0] {S_HDR, S_ECHO, S_OPND, S_AREQ, S_AWAIT, S_SEND, S_DRAIN} state_t;

  state_t           state, state_n;
  logic [1:0]       hcnt;
  logic [7:0]       hdr_op, len_lsb;
  logic [15:0]      bcnt;
  logic [BW-1:0]    bidx, sidx;
  logic             first, live, err;
  logic [DataW-1:0] opnd, acc, opnd_n, acc_sh;
  logic [TW-1:0]    tcnt;

  logic        en, rx_ready, tx_valid, alu_valid;
  logic [7:0]  tx_data;
  logic        rx_hs, tx_hs, alu_hs, res_hit, tmo_run, tmo_hit;
  logic [15:0] len_w, pay_w;
  logic        op_ok, len_ok, hdr_err;
  logic [1:0]  op_code;

  // live holds outputs low for the first cycle after reset releases
  assign en     = live & ~rst_i;
  assign len_w  = {bus.rx_data_i, len_lsb};
  assign pay_w  = len_w - 16'd4;
  assign acc_sh = acc >> {sidx, 3'b000};
  assign opnd_n = (opnd & ~({{(DataW-8){1'b0}}, 8'hFF} << {bidx, 3'b000}))
                | ({{(DataW-8){1'b0}}, bus.rx_data_i} << {bidx, 3'b000});

  always_comb begin
    op_ok   = 1'b1;
    len_ok  = 1'b0;
    op_code = 2'b00;
    case (hdr_op)
      8'hEC: len_ok = 1'b1;
      8'hA0: len_ok = (pay_w >= 16'(NB)) && (pay_w % 16'(NB) == 16'd0);
      8'hB0: begin
        op_code = 2'b01;
        len_ok  = (pay_w >= 16'(NB)) && (pay_w % 16'(NB) == 16'd0);
      end
      8'hC0: begin
        op_code = 2'b10;
        len_ok  = (pay_w == 16'(2 * NB));
      end
      default: op_ok = 1'b0;
    endcase
    hdr_err = (len_w < 16'd4) || !(op_ok && len_ok);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_HDR;
    else       state <= state_n;
  end

  always_comb begin
    rx_ready  = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    alu_valid = 1'b0;
    case (state)
      S_HDR, S_OPND, S_DRAIN: rx_ready = en;
      S_ECHO: begin
        rx_ready = en & bus.tx_ready_i;
        tx_valid = en & bus.rx_valid_i;
        tx_data  = en ? bus.rx_data_i : 8'h00;
      end
      S_AREQ: alu_valid = en;
      S_SEND: begin
        tx_valid = en;
        tx_data  = en ? acc_sh[7:0] : 8'h00;
      end
      default: ;
    endcase
    rx_hs   = rx_ready & bus.rx_valid_i;
    tx_hs   = tx_valid & bus.tx_ready_i;
    alu_hs  = alu_valid & bus.alu_ready_i;
    res_hit = en & (state == S_AWAIT) & bus.alu_res_valid_i;
    tmo_run = ((state == S_HDR) && (hcnt != 2'd0)) || (state == S_OPND) || (state == S_DRAIN);
    tmo_hit = en & tmo_run & ~rx_hs & (tcnt == T_LAST);

    state_n = state;
    case (state)
      S_HDR: if (rx_hs && hcnt == 2'd3) begin
        if (len_w <= 16'd4) state_n = S_HDR;
        else if (hdr_err)   state_n = S_DRAIN;
        else                state_n = (hdr_op == 8'hEC) ? S_ECHO : S_OPND;
      end
      S_ECHO, S_DRAIN: if (rx_hs && bcnt == 16'd1) state_n = S_HDR;
      S_OPND: if (rx_hs && bidx == LAST_B) begin
        if (!first)                state_n = S_AREQ;
        else if (bcnt == 16'd1)    state_n = S_SEND;
      end
      S_AREQ:  if (alu_hs) state_n = S_AWAIT;
      S_AWAIT: if (res_hit) state_n = (bcnt != 16'd0) ? S_OPND : S_SEND;
      S_SEND:  if (tx_hs && sidx == LAST_B) state_n = S_HDR;
      default: state_n = S_HDR;
    endcase
    if (tmo_hit) state_n = S_HDR;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      live <= 1'b0; err <= 1'b0; hcnt <= '0; hdr_op <= '0; len_lsb <= '0;
      bcnt <= '0; bidx <= '0; sidx <= '0; first <= 1'b1;
      opnd <= '0; acc <= '0; tcnt <= '0;
    end else begin
      live <= 1'b1;
      err  <= 1'b0;
      if (rx_hs || !tmo_run || tmo_hit) tcnt <= '0;
      else                              tcnt <= tcnt + TW'(1);
      case (state)
        S_HDR: if (rx_hs) begin
          hcnt <= hcnt + 2'd1;
          if (hcnt == 2'd0) hdr_op  <= bus.rx_data_i;
          if (hcnt == 2'd2) len_lsb <= bus.rx_data_i;
          if (hcnt == 2'd3) begin
            err   <= hdr_err;
            bcnt  <= (len_w < 16'd4) ? 16'd0 : pay_w;
            bidx  <= '0;
            first <= 1'b1;
          end
        end
        S_ECHO, S_DRAIN: if (rx_hs && bcnt != 16'd0) bcnt <= bcnt - 16'd1;
        S_OPND: if (rx_hs) begin
          if (bcnt != 16'd0) bcnt <= bcnt - 16'd1;
          opnd <= opnd_n;
          bidx <= (bidx == LAST_B) ? '0 : bidx + BW'(1);
          if (bidx == LAST_B && first) begin
            acc   <= opnd_n;
            first <= 1'b0;
          end
        end
        S_AWAIT: if (res_hit) acc <= bus.alu_res_i;
        S_SEND:  if (tx_hs) sidx <= (sidx == LAST_B) ? '0 : sidx + BW'(1);
        default: ;
      endcase
      // timeout drops whatever partial packet was held
      if (tmo_hit) begin
        err   <= 1'b1;
        hcnt  <= '0;
        bcnt  <= '0;
        bidx  <= '0;
        first <= 1'b1;
      end
    end
  end

  assign bus.rx_ready_o  = rx_ready;
  assign bus.tx_valid_o  = tx_valid;
  assign bus.tx_data_o   = tx_data;
  assign bus.alu_valid_o = alu_valid;
  assign bus.alu_op_o    = alu_valid ? op_code : 2'b00;
  assign bus.alu_a_o     = alu_valid ? acc : '0;
  assign bus.alu_b_o     = alu_valid ? opnd : '0;
  assign bus.err_o       = err & en;
endmodule
